// File: rtl/control_unit_multicycle.sv
// rtl/control_unit_multicycle.sv - Moore control FSM for the multicycle datapath
// Decodes IR[31:26] and stretches memory access states by MEM_WAIT extra cycles.
module control_unit_multicycle #(
  parameter int MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       bad_opcode
);

  localparam logic [2:0] LP_WAIT = 3'(MEM_WAIT);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [3:0] {
    S_RESET, S_FETCH, S_DECODE, S_RTYPE_EX, S_RTYPE_WB, S_ADDI_EX, S_ADDI_WB,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BEQ, S_JUMP, S_BADOP
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_wait_cnt;
  logic       w_wait_done;
  logic       w_unused_zero;

  // The branch decision is made in the datapath from pc_write_cond & zero.
  assign w_unused_zero = zero;
  assign w_wait_done   = (r_wait_cnt == LP_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_RESET;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) begin
        r_wait_cnt <= '0;
      end else if (!w_wait_done) begin
        r_wait_cnt <= r_wait_cnt + 3'd1;
      end
    end
  end

  always_comb begin
    w_next_state = S_RESET;
    case (r_state)
      S_RESET:    w_next_state = S_FETCH;
      S_FETCH:    w_next_state = w_wait_done ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     w_next_state = S_RTYPE_EX;
          OP_ADDI:      w_next_state = S_ADDI_EX;
          OP_LW, OP_SW: w_next_state = S_MEM_ADDR;
          OP_BEQ:       w_next_state = S_BEQ;
          OP_J:         w_next_state = S_JUMP;
          default:      w_next_state = S_BADOP;
        endcase
      end
      S_RTYPE_EX: w_next_state = S_RTYPE_WB;
      S_RTYPE_WB: w_next_state = S_FETCH;
      S_ADDI_EX:  w_next_state = S_ADDI_WB;
      S_ADDI_WB:  w_next_state = S_FETCH;
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      w_next_state = S_MEM_RD;
        else if (opcode == OP_SW) w_next_state = S_MEM_WR;
        else                      w_next_state = S_BADOP;
      end
      S_MEM_RD:   w_next_state = w_wait_done ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   w_next_state = S_FETCH;
      S_MEM_WR:   w_next_state = w_wait_done ? S_FETCH : S_MEM_WR;
      S_BEQ:      w_next_state = S_FETCH;
      S_JUMP:     w_next_state = S_FETCH;
      S_BADOP:    w_next_state = S_BADOP;
      default:    w_next_state = S_RESET;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    bad_opcode    = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        // PC+4 and IR load only once the instruction word is valid.
        pc_write  = w_wait_done;
        ir_write  = w_wait_done;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_RTYPE_EX: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_RTYPE_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_ADDI_EX, S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB:  reg_write = 1'b1;
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_BADOP:    bad_opcode = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_control_unit_multicycle.sv
// tb/tb_control_unit_multicycle.sv - randomized check of three FSM instances (W=1,2,0)
// Expected strobe sequences are built per instruction from the control table.
module tb_control_unit_multicycle;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        zero  = 1'b0;
  logic [5:0]  op [3];
  logic [16:0] obs [3];

  int n_checks = 0;
  int n_errors = 0;

  logic [16:0] exp_buf [3][64];
  logic [16:0] last_exp [3];
  int          head [3];
  int          tail [3];
  bit          hit;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic       pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, asa, bad;
    logic [1:0] asb, aop, psrc;
    control_unit_multicycle #(.MEM_WAIT((g == 0) ? 1 : (g == 1) ? 2 : 0)) u_dut (
      .clk(clk), .reset(reset), .opcode(op[g]), .zero(zero),
      .pc_write(pcw), .pc_write_cond(pcwc), .iord(iord), .mem_read(mr),
      .mem_write(mw), .ir_write(irw), .reg_dst(rd), .mem_to_reg(m2r),
      .reg_write(rw), .alu_src_a(asa), .alu_src_b(asb), .alu_op(aop),
      .pc_source(psrc), .bad_opcode(bad)
    );
    assign obs[g] = {pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, bad};
  end

  function automatic int wof(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 0;
  endfunction

  function automatic logic [16:0] vec(input bit pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, asa,
                                      input bit [1:0] asb, aop, psrc, input bit bad);
    return {pcw, pcwc, iord, mr, mw, irw, rd, m2r, rw, asa, asb, aop, psrc, bad};
  endfunction

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 5))
      0:       return 6'h00;
      1:       return 6'h08;
      2:       return 6'h23;
      3:       return 6'h2B;
      4:       return 6'h04;
      default: return 6'h02;
    endcase
  endfunction

  task automatic push(input int k, input logic [16:0] v);
    exp_buf[k][tail[k]] = v;
    tail[k]++;
  endtask

  // Whole-instruction expectation: fetch, decode, then the opcode's execute path.
  task automatic load_instr(input int k, input logic [5:0] opc, input int nbad);
    int w;
    w = wof(k);
    head[k] = 0;
    tail[k] = 0;
    op[k]   = opc;
    for (int i = 0; i <= w; i++)
      push(k, vec(i == w, 0, 0, 1, 0, i == w, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    push(k, vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 2'b00, 0));
    case (opc)
      6'h00: begin
        push(k, vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 2'b00, 0));
        push(k, vec(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));
      end
      6'h08: begin
        push(k, vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0));
        push(k, vec(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 0));
      end
      6'h23: begin
        push(k, vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0));
        for (int i = 0; i <= w; i++)
          push(k, vec(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        push(k, vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0));
      end
      6'h2B: begin
        push(k, vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0));
        for (int i = 0; i <= w; i++)
          push(k, vec(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
      end
      6'h04: push(k, vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 2'b01, 0));
      6'h02: push(k, vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b10, 0));
      default: repeat (nbad) push(k, vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1));
    endcase
  endtask

  task automatic chk(input string tag, input logic [16:0] o, input logic [16:0] e);
    n_checks++;
    assert (o === e) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick_check();
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (head[k] < tail[k]) begin
        chk($sformatf("dut%0d_seq%0d", k, head[k]), obs[k], exp_buf[k][head[k]]);
        last_exp[k] = exp_buf[k][head[k]];
        head[k]++;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 3; k++) chk($sformatf("%s_dut%0d", tag, k), obs[k], 17'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      op[k] = 6'h00;
      head[k] = 0;
      tail[k] = 0;
      last_exp[k] = '0;
    end
    hit = 1'b0;

    repeat (3) begin
      @(posedge clk);
      #1;
      chk_all_zero("reset_hold");
    end

    load_instr(0, 6'h00, 0);
    load_instr(1, 6'h23, 0);
    load_instr(2, 6'h2B, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int c = 0; c < 600 && !hit; c++) begin
      tick_check();
      if (c >= 150 && last_exp[2][12]) begin
        hit = 1'b1;
      end else begin
        zero = 1'($urandom);
        for (int k = 0; k < 3; k++)
          if (head[k] >= tail[k]) load_instr(k, pick_op(), 0);
      end
    end
    chk("memwr_reached", 17'(hit), 17'd1);

    // Abort in MEM_WR: strobes must drop in the same cycle reset rises.
    reset = 1'b1;
    #1;
    chk_all_zero("abort_reset");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_all_zero("abort_hold");
    end

    for (int k = 0; k < 3; k++) load_instr(k, 6'h3F, 20);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 30; c++) tick_check();

    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_all_zero("bad_cleared");
    for (int k = 0; k < 3; k++) load_instr(k, pick_op(), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) tick_check();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
